ssb_subcarrier_extractor: RTL and testbench

- Sits directly downstream of the FFT demodulator stage.
- Consumes per-symbol FFT bin streams tagged with SSS/PBCH start pulses.
- Keeps only the occupied SSB subcarriers: 127 for SSS, 240 for PBCH.
- Emits them on a backpressured AXI-stream with tlast per symbol and a symbol-type tuser, buffered by an internal FIFO, for the SSS detector and PBCH channel estimator.

---
 rtl/ssb_pkg.sv | 23 ++
 rtl/axis_fifo_fwft.sv | 55 +++++
 rtl/ssb_subcarrier_extractor.sv | 132 +++++++++++++
 tb/tb_ssb_subcarrier_extractor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssb_pkg.sv
// Shared constants and types for the SSB subcarrier extractor.
// The SSS and PBCH windows are centred on DC of the fft-shifted spectrum.
package ssb_pkg;

  localparam int SSS_LEN   = 127;
  localparam int PBCH_LEN  = 240;
  localparam int SSS_HALF  = 63;
  localparam int PBCH_HALF = 120;

  // Also the tuser encoding on the output stream.
  typedef enum logic [1:0] {
    SYM_NONE = 2'b00,
    SYM_SSS  = 2'b01,
    SYM_PBCH = 2'b10
  } sym_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SSS_SYM  = 2'b01,
    PBCH_SYM = 2'b10
  } state_t;

endpackage

// File: rtl/axis_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module axis_fifo_fwft #(
  parameter int W     = 35,
  parameter int DEPTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         wr_drop,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         rd_fire;
  logic         wr_fire;

  // The extra pointer MSB tells a full FIFO from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = !empty;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_en && (!full || rd_fire);
  assign wr_drop  = wr_en && full && !rd_fire;
  assign level    = wr_ptr - rd_ptr;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, and a reset port would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ssb_subcarrier_extractor.sv
// Extracts the occupied SSS/PBCH subcarriers from an FFT bin stream and
// emits them per symbol on a backpressured AXI-stream through a FWFT FIFO.
module ssb_subcarrier_extractor
  import ssb_pkg::*;
#(
  parameter int IN_DW      = 32,
  parameter int FFT_LEN    = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [IN_DW-1:0]              s_axis_in_tdata,
  input  logic                          s_axis_in_tvalid,
  input  logic                          SSS_start_i,
  input  logic                          PBCH_start_i,
  output logic [IN_DW-1:0]              m_axis_out_tdata,
  output logic                          m_axis_out_tvalid,
  input  logic                          m_axis_out_tready,
  output logic                          m_axis_out_tlast,
  output logic [1:0]                    m_axis_out_tuser,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          sym_error_o
);

  localparam int BW = $clog2(FFT_LEN);
  localparam int C  = FFT_LEN / 2;
  localparam int FW = IN_DW + 3;

  localparam logic [BW-1:0] SSS_LO   = BW'(C - SSS_HALF);
  localparam logic [BW-1:0] SSS_HI   = BW'(C - SSS_HALF + SSS_LEN - 1);
  localparam logic [BW-1:0] PBCH_LO  = BW'(C - PBCH_HALF);
  localparam logic [BW-1:0] PBCH_HI  = BW'(C - PBCH_HALF + PBCH_LEN - 1);
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_LEN - 1);

  state_t        state;
  logic [BW-1:0] bin_cnt;
  logic          sss_go;
  logic          pbch_go;
  sym_t          cur_sym;
  logic [BW-1:0] cur_bin;
  logic          keep;
  logic          last;
  logic          wr_en;
  logic [FW-1:0] wr_data;
  logic          wr_drop;
  logic [FW-1:0] rd_data;

  assign sss_go  = s_axis_in_tvalid && SSS_start_i;
  assign pbch_go = s_axis_in_tvalid && PBCH_start_i;

  // A lone start makes this sample bin 0 of the new symbol; a double start
  // classifies the sample as belonging to no symbol.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_sym = SYM_NONE;
    cur_bin = bin_cnt;
    keep    = 1'b0;
    last    = 1'b0;
    if (sss_go ^ pbch_go) begin
      cur_sym = sss_go ? SYM_SSS : SYM_PBCH;
      cur_bin = '0;
    end else if (!sss_go && !pbch_go) begin
      case (state)
        SSS_SYM:  cur_sym = SYM_SSS;
        PBCH_SYM: cur_sym = SYM_PBCH;
        default:  cur_sym = SYM_NONE;
      endcase
    end
    if (s_axis_in_tvalid) begin
      case (cur_sym)
        SYM_SSS: begin
          keep = (cur_bin >= SSS_LO) && (cur_bin <= SSS_HI);
          last = (cur_bin == SSS_HI);
        end
        SYM_PBCH: begin
          keep = (cur_bin >= PBCH_LO) && (cur_bin <= PBCH_HI);
          last = (cur_bin == PBCH_HI);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      bin_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      sym_error_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      wr_en       <= keep;
      wr_data     <= {cur_sym, last, s_axis_in_tdata};
      sym_error_o <= (sss_go && pbch_go) || ((sss_go || pbch_go) && state != IDLE);
      if (wr_drop) overflow_o <= 1'b1;
      if (s_axis_in_tvalid) begin
        if (sss_go && pbch_go) begin
          state <= IDLE;
        end else if (sss_go || pbch_go) begin
          state   <= sss_go ? SSS_SYM : PBCH_SYM;
          bin_cnt <= BW'(1);
        end else if (state != IDLE) begin
          bin_cnt <= bin_cnt + 1'b1;
          if (bin_cnt == LAST_BIN) state <= IDLE;
        end
      end
    end
  end

  axis_fifo_fwft #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (reset_i),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop),
    .rd_valid (m_axis_out_tvalid),
    .rd_ready (m_axis_out_tready),
    .rd_data  (rd_data),
    .level    (fifo_level_o)
  );

  assign m_axis_out_tdata = rd_data[IN_DW-1:0];
  assign m_axis_out_tlast = rd_data[IN_DW];
  assign m_axis_out_tuser = rd_data[IN_DW+2:IN_DW+1];

endmodule

// File: tb/tb_ssb_subcarrier_extractor.sv
// Directed bench for ssb_subcarrier_extractor: a queue model of the output
// stream checked every cycle, plus literal expectations per scenario.
module tb_ssb_subcarrier_extractor;

  localparam int FFT_LEN = 256;
  localparam int DEPTH   = 256;
  localparam int C       = FFT_LEN / 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  user;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, sss, pbch;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, tready;
  logic [1:0]  m_tuser;
  logic [8:0]  level;
  logic        overflow, sym_error;

  // Expected classification of the sample currently driven.
  logic        exp_keep, exp_last, exp_err;
  logic [1:0]  exp_user;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lo_cyc, first_v_cyc, max_level, errs;

  item_t mq[$];
  item_t out_log[$];
  item_t pend;
  logic  pend_v = 1'b0;
  logic  m_ovf  = 1'b0;
  logic  m_err  = 1'b0;

  ssb_subcarrier_extractor #(
    .IN_DW      (32),
    .FFT_LEN    (FFT_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i             (clk),
    .reset_i           (rst),
    .s_axis_in_tdata   (in_data),
    .s_axis_in_tvalid  (in_valid),
    .SSS_start_i       (sss),
    .PBCH_start_i      (pbch),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (m_tlast),
    .m_axis_out_tuser  (m_tuser),
    .fifo_level_o      (level),
    .overflow_o        (overflow),
    .sym_error_o       (sym_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Model: a kept sample enters the queue one edge after it is sampled;
  // the head leaves on ready; a kept sample finding the queue full is lost.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      pend_v = 1'b0;
      m_ovf  = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (mq.size() > 0 && tready) mq.delete(0);
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend);
        else m_ovf = 1'b1;
      end
      pend_v = in_valid & exp_keep;
      pend   = '{data: in_data, last: exp_last, user: exp_user};
      m_err  = in_valid & exp_err;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("tvalid", 32'(m_tvalid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("tdata", m_tdata, mq[0].data);
        check("tlast", 32'(m_tlast), 32'(mq[0].last));
        check("tuser", 32'(m_tuser), 32'(mq[0].user));
      end
      check("level", 32'(level), 32'(mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("sym_error", 32'(sym_error), 32'(m_err));
      if (m_tvalid && tready) out_log.push_back('{data: m_tdata, last: m_tlast, user: m_tuser});
      if (int'(level) > max_level) max_level = int'(level);
      if (sym_error) errs++;
      if (m_tvalid && first_v_cyc < 0) first_v_cyc = cyc;
    end
  end

  task automatic drive(input logic v, input logic ss, input logic pb, input logic [31:0] d,
                       input logic keep, input logic lst, input logic [1:0] user, input logic err);
    in_valid = v;  sss = ss;  pbch = pb;  in_data = d;
    exp_keep = keep;  exp_last = lst;  exp_user = user;  exp_err = err;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Sends bins 0..nbins-1 of one symbol; with gap, an invalid cycle carrying
  // a stray start pulse precedes every bin after the first.
  task automatic send_symbol(input logic [1:0] typ, input int nbins, input bit gap, input logic err0);
    int lo, hi;
    lo = (typ == 2'b01) ? C - 63 : C - 120;
    hi = (typ == 2'b01) ? C + 63 : C + 119;
    for (int b = 0; b < nbins; b++) begin
      if (gap && b > 0) drive(1'b0, 1'b1, 1'b0, 32'hdead, 1'b0, 1'b0, 2'b00, 1'b0);
      if (b == lo) lo_cyc = cyc;
      drive(1'b1, b == 0 && typ == 2'b01, b == 0 && typ == 2'b10, 32'(b),
            b >= lo && b <= hi, b == hi, typ, b == 0 && err0);
    end
    in_valid = 1'b0;  sss = 1'b0;  pbch = 1'b0;
    exp_keep = 1'b0;  exp_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq_ok;
    rst = 1'b1;  in_valid = 1'b0;  sss = 1'b0;  pbch = 1'b0;  in_data = '0;  tready = 1'b0;
    exp_keep = 1'b0;  exp_last = 1'b0;  exp_user = 2'b00;  exp_err = 1'b0;
    first_v_cyc = -1;  max_level = 0;  errs = 0;
    #1;
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_tuser", 32'(m_tuser), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_sym_error", 32'(sym_error), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // SSS symbol, free-flowing output
    tready = 1'b1;
    out_log.delete();
    first_v_cyc = -1;
    send_symbol(2'b01, FFT_LEN, 1'b0, 1'b0);
    idle(10);
    check("sss_count", out_log.size(), 127);
    check("sss_first", out_log[0].data, 65);
    check("sss_lastval", out_log[126].data, 191);
    check("sss_tlast", 32'(out_log[126].last), 1);
    check("sss_early_tlast", 32'(out_log[125].last), 0);
    check("sss_tuser", 32'(out_log[0].user), 32'h1);
    check("sss_latency", 32'(first_v_cyc - lo_cyc), 2);

    // PBCH followed back-to-back by SSS
    out_log.delete();
    send_symbol(2'b10, FFT_LEN, 1'b0, 1'b0);
    send_symbol(2'b01, FFT_LEN, 1'b0, 1'b0);
    idle(10);
    check("pb_ss_count", out_log.size(), 367);
    check("pb_first", out_log[0].data, 8);
    check("pb_lastval", out_log[239].data, 247);
    check("pb_tlast", 32'(out_log[239].last), 1);
    check("pb_tuser", 32'(out_log[0].user), 32'h2);
    check("pb_then_ss_first", out_log[240].data, 65);
    check("pb_then_ss_tuser", 32'(out_log[240].user), 32'h1);
    check("pb_then_ss_last", out_log[366].data, 191);

    // Backpressure over a whole PBCH symbol
    tready = 1'b0;
    out_log.delete();
    max_level = 0;
    send_symbol(2'b10, FFT_LEN, 1'b0, 1'b0);
    idle(5);
    check("bp_peak_level", 32'(max_level), 240);
    check("bp_overflow", 32'(overflow), 0);
    tready = 1'b1;
    idle(260);
    check("bp_count", out_log.size(), 240);
    check("bp_first", out_log[0].data, 8);
    check("bp_lastval", out_log[239].data, 247);

    // Overflow: PBCH then SSS into a 256-entry FIFO with no reads
    tready = 1'b0;
    out_log.delete();
    send_symbol(2'b10, FFT_LEN, 1'b0, 1'b0);
    send_symbol(2'b01, FFT_LEN, 1'b0, 1'b0);
    idle(3);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_level", 32'(level), 256);
    tready = 1'b1;
    idle(300);
    check("ovf_count", out_log.size(), 256);
    check("ovf_pb_last", out_log[239].data, 247);
    check("ovf_ss_first", out_log[240].data, 65);
    check("ovf_tail", out_log[255].data, 80);
    check("ovf_tail_tlast", 32'(out_log[255].last), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Both starts in one cycle: error pulse and nothing written
    out_log.delete();
    errs = 0;
    drive(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    for (int b = 1; b < FFT_LEN; b++) drive(1'b1, 1'b0, 1'b0, 32'(b), 1'b0, 1'b0, 2'b00, 1'b0);
    idle(5);
    check("conflict_count", out_log.size(), 0);
    check("conflict_errs", 32'(errs), 1);

    // SSS start at bin 100 of a PBCH symbol
    out_log.delete();
    errs = 0;
    send_symbol(2'b10, 100, 1'b0, 1'b0);
    send_symbol(2'b01, FFT_LEN, 1'b0, 1'b1);
    idle(10);
    check("restart_count", out_log.size(), 219);
    check("restart_pb_tail", out_log[91].data, 99);
    check("restart_pb_no_tlast", 32'(out_log[91].last), 0);
    check("restart_ss_first", out_log[92].data, 65);
    check("restart_ss_tuser", 32'(out_log[92].user), 32'h1);
    check("restart_ss_tlast", 32'(out_log[218].last), 1);
    check("restart_errs", 32'(errs), 1);

    // Gapped valid with stray start pulses on the invalid cycles
    out_log.delete();
    send_symbol(2'b01, FFT_LEN, 1'b1, 1'b0);
    idle(10);
    check("gap_count", out_log.size(), 127);
    seq_ok = 1;
    for (int i = 0; i < out_log.size() && i < 127; i++)
      if (out_log[i].data != 32'(65 + i)) seq_ok = 0;
    check("gap_sequence", 32'(seq_ok), 1);
    check("gap_tlast", 32'(out_log[126].last), 1);

    // Asynchronous reset in the middle of a backpressured PBCH symbol
    tready = 1'b0;
    send_symbol(2'b10, 150, 1'b1, 1'b0);
    check("pre_reset_level_nonzero", 32'(level != 0), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(m_tvalid), 0);
    check("arst_tdata", m_tdata, 0);
    check("arst_tlast", 32'(m_tlast), 0);
    check("arst_tuser", 32'(m_tuser), 0);
    check("arst_level", 32'(level), 0);
    check("arst_overflow", 32'(overflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tready = 1'b1;
    idle(5);
    check("post_reset_tvalid", 32'(m_tvalid), 0);
    check("post_reset_level", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
